// File: rtl/axi_write_ctrl.sv
`timescale 1ns/1ps
// AXI4-Lite write-execution stage: collects AW and W in any order, performs one
// checked memory write and hands a one-cycle response strobe to the B stage.
module axi_write_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_BYTES  = 1024,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WEN,
    output logic [ADDR_WIDTH-1:0] MADDR,
    output logic [STRB_WIDTH-1:0] MSTRB,
    output logic [DATA_WIDTH-1:0] MDATA,
    input  logic                  MACK,
    input  logic                  MERR,
    output logic                  WRESPREADY,
    output logic [1:0]            WRESP,
    input  logic                  BRESPREADY
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT  = ADDR_WIDTH'(MEM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST   = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        RESP   = 2'd2,
        WAIT_B = 2'd3
    } state_t;

    function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] addr);
        return (addr < MEM_LIMIT) && ((addr & ALIGN_MASK) == '0);
    endfunction

    state_t                  state_r, state_s;
    logic                    started_r;
    logic                    aw_held_r, aw_held_s;
    logic                    w_held_r, w_held_s;
    logic [CNT_WIDTH-1:0]    cnt_r, cnt_s;
    logic                    awready_r, awready_s;
    logic                    wready_r, wready_s;
    logic                    wen_r, wen_s;
    logic                    wrespready_r, wrespready_s;
    logic [1:0]              wresp_r, wresp_s;
    logic [ADDR_WIDTH-1:0]   maddr_r, maddr_s;
    logic [STRB_WIDTH-1:0]   mstrb_r, mstrb_s;
    logic [DATA_WIDTH-1:0]   mdata_r, mdata_s;
    logic                    aw_hs_s, w_hs_s, aw_got_s, w_got_s;

    // Next-state and next-output computation; every output is a register fed from here.
    always_comb begin
        aw_hs_s      = AWVALID && awready_r;
        w_hs_s       = WVALID && wready_r;
        aw_got_s     = aw_held_r || aw_hs_s;
        w_got_s      = w_held_r || w_hs_s;
        state_s      = state_r;
        aw_held_s    = aw_held_r;
        w_held_s     = w_held_r;
        cnt_s        = cnt_r;
        awready_s    = 1'b0;
        wready_s     = 1'b0;
        wen_s        = 1'b0;
        wrespready_s = 1'b0;
        wresp_s      = wresp_r;
        maddr_s      = maddr_r;
        mstrb_s      = mstrb_r;
        mdata_s      = mdata_r;
        case (state_r)
            IDLE: begin
                if (aw_hs_s) begin
                    maddr_s = AWADDR;
                end else begin
                    maddr_s = maddr_r;
                end
                if (w_hs_s) begin
                    mstrb_s = WSTRB;
                    mdata_s = WDATA;
                end else begin
                    mstrb_s = mstrb_r;
                    mdata_s = mdata_r;
                end
                // Decide on the handshake cycle itself so WEN or the strobe lands one cycle later.
                if (aw_got_s && w_got_s) begin
                    aw_held_s = 1'b0;
                    w_held_s  = 1'b0;
                    if (!addr_legal(maddr_s)) begin
                        state_s      = RESP;
                        wrespready_s = 1'b1;
                        wresp_s      = RESP_SLVERR;
                    end else if (mstrb_s == '0) begin
                        state_s      = RESP;
                        wrespready_s = 1'b1;
                        wresp_s      = RESP_OKAY;
                    end else begin
                        state_s = WRITE;
                        wen_s   = 1'b1;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    aw_held_s = aw_got_s;
                    w_held_s  = w_got_s;
                    awready_s = started_r && !aw_got_s;
                    wready_s  = started_r && !w_got_s;
                end
            end
            WRITE: begin
                if (MACK) begin
                    state_s      = RESP;
                    wrespready_s = 1'b1;
                    wresp_s      = MERR ? RESP_SLVERR : RESP_OKAY;
                end else if (cnt_r == CNT_LAST) begin
                    state_s      = RESP;
                    wrespready_s = 1'b1;
                    wresp_s      = RESP_SLVERR;
                end else begin
                    wen_s = 1'b1;
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RESP: begin
                state_s = WAIT_B;
            end
            WAIT_B: begin
                if (BRESPREADY) begin
                    state_s   = IDLE;
                    awready_s = 1'b1;
                    wready_s  = 1'b1;
                end else begin
                    state_s = WAIT_B;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= IDLE;
            started_r    <= 1'b0;
            aw_held_r    <= 1'b0;
            w_held_r     <= 1'b0;
            cnt_r        <= '0;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            wen_r        <= 1'b0;
            wrespready_r <= 1'b0;
            wresp_r      <= 2'b00;
            maddr_r      <= '0;
            mstrb_r      <= '0;
            mdata_r      <= '0;
        end else begin
            state_r      <= state_s;
            started_r    <= 1'b1;
            aw_held_r    <= aw_held_s;
            w_held_r     <= w_held_s;
            cnt_r        <= cnt_s;
            awready_r    <= awready_s;
            wready_r     <= wready_s;
            wen_r        <= wen_s;
            wrespready_r <= wrespready_s;
            wresp_r      <= wresp_s;
            maddr_r      <= maddr_s;
            mstrb_r      <= mstrb_s;
            mdata_r      <= mdata_s;
        end
    end

    assign AWREADY    = awready_r;
    assign WREADY     = wready_r;
    assign WEN        = wen_r;
    assign WRESPREADY = wrespready_r;
    assign WRESP      = wresp_r;
    assign MADDR      = maddr_r;
    assign MSTRB      = mstrb_r;
    assign MDATA      = mdata_r;

endmodule

// File: tb/tb_axi_write_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for axi_write_ctrl: driver pushes expected outcomes, a
// negedge monitor checks memory writes and response strobes against them.
module tb_axi_write_ctrl;

    localparam int TIMEOUT   = 15;
    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, MACK = 1'b0, MERR = 1'b0, BRESPREADY = 1'b0;
    logic [31:0] AWADDR = 32'd0, WDATA = 32'd0;
    logic [3:0]  WSTRB = 4'd0;
    logic        AWREADY, WREADY, WEN, WRESPREADY;
    logic [31:0] MADDR, MDATA;
    logic [3:0]  MSTRB;
    logic [1:0]  WRESP;

    int tests = 0;
    int fails = 0;
    int wen_cnt = 0;

    typedef struct {
        logic [1:0]  resp;
        int          wen_cycles;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;
    exp_t exp_q[$];

    axi_write_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
                     .MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .WEN(WEN), .MADDR(MADDR), .MSTRB(MSTRB), .MDATA(MDATA),
        .MACK(MACK), .MERR(MERR),
        .WRESPREADY(WRESPREADY), .WRESP(WRESP), .BRESPREADY(BRESPREADY)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: memory-side writes and response strobes are checked against the queue.
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            wen_cnt = 0;
        end else begin
            if (WEN) begin
                wen_cnt++;
                if (exp_q.size() == 0) begin
                    check("wen_without_txn", 64'd1, 64'd0);
                end else begin
                    check("maddr", MADDR, exp_q[0].addr);
                    check("mdata", MDATA, exp_q[0].data);
                    check("mstrb", MSTRB, exp_q[0].strb);
                end
            end
            if (WRESPREADY) begin
                if (exp_q.size() == 0) begin
                    check("resp_without_txn", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wresp", WRESP, e.resp);
                    check("wen_cycles", wen_cnt, e.wen_cycles);
                end
                wen_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0; AWVALID = 1'b1; WVALID = 1'b1; MACK = 1'b0; BRESPREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ctrl", {AWREADY, WREADY, WEN, WRESPREADY, WRESP}, 64'd0);
            check("rst_data", {MADDR, MSTRB, MDATA}, 64'd0);
        end
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_ctrl", {AWREADY, WREADY, WEN, WRESPREADY, WRESP}, 64'd0);
        check("post_rst_data", {MADDR, MSTRB, MDATA}, 64'd0);
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {AWREADY, WREADY, WEN, WRESPREADY}, 64'hC);
    endtask

    // order: 0 same cycle, 1 AW first, 2 W first; d: WEN cycle index of MACK;
    // abort: 1 reset during WRITE, 2 reset during WAIT_B.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int order, input int gap, input int d, input logic merr,
                          input int bdelay, input int abort);
        exp_t e;
        int   lat, exp_lat, wen_idx, aw_start, w_start;
        logic aw_done, w_done, got;
        e.addr = addr; e.data = data; e.strb = strb;
        if (!(addr < MEM_BYTES && addr % 4 == 0)) begin
            e.resp = 2'b10; e.wen_cycles = 0; exp_lat = 1;
        end else if (strb == 4'd0) begin
            e.resp = 2'b00; e.wen_cycles = 0; exp_lat = 1;
        end else if (d < TIMEOUT) begin
            e.resp = merr ? 2'b10 : 2'b00; e.wen_cycles = d + 1; exp_lat = d + 2;
        end else begin
            e.resp = 2'b10; e.wen_cycles = TIMEOUT; exp_lat = TIMEOUT + 1;
        end
        aw_start = (order == 2) ? gap : 0;
        w_start  = (order == 1) ? gap : 0;
        aw_done = 1'b0; w_done = 1'b0;
        for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
            @(negedge clk);
            check(aw_done ? "awready_after_hs" : "awready_idle", AWREADY, aw_done ? 64'd0 : 64'd1);
            check(w_done ? "wready_after_hs" : "wready_idle", WREADY, w_done ? 64'd0 : 64'd1);
            MACK = 1'($urandom % 2); MERR = 1'($urandom % 2);
            BRESPREADY = ($urandom % 4 == 0);
            AWVALID = !aw_done && c >= aw_start;
            WVALID  = !w_done && c >= w_start;
            AWADDR  = AWVALID ? addr : $urandom;
            WDATA   = WVALID ? data : $urandom;
            WSTRB   = WVALID ? strb : 4'($urandom);
            if (AWVALID && AWREADY) aw_done = 1'b1;
            if (WVALID && WREADY) w_done = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            check("handshake_timeout", 64'd1, 64'd0);
            do_reset();
            return;
        end
        exp_q.push_back(e);
        wen_idx = 0; lat = 0; got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            AWVALID = 1'b0; WVALID = 1'b0; BRESPREADY = 1'b0;
            if (abort == 1 && wen_idx == 3) begin
                do_reset();
                return;
            end
            if (WRESPREADY) begin
                got = 1'b1; lat = c; MACK = 1'b0;
                BRESPREADY = 1'($urandom % 2);
            end else begin
                MACK = WEN && (wen_idx == d);
                MERR = MACK ? merr : 1'($urandom % 2);
                if (WEN) wen_idx++;
            end
        end
        check("resp_latency", lat, exp_lat);
        for (int i = 0; i <= bdelay; i++) begin
            @(negedge clk);
            check("blocked_in_wait_b", {AWREADY, WREADY, WEN, WRESPREADY}, 64'd0);
            if (abort == 2) begin
                do_reset();
                return;
            end
            if (i == bdelay) begin
                BRESPREADY = 1'b1; AWVALID = 1'b0; WVALID = 1'b0;
            end else begin
                BRESPREADY = 1'b0; AWVALID = 1'b1; WVALID = 1'b1;
                AWADDR = $urandom; WDATA = $urandom;
            end
        end
        @(negedge clk);
        BRESPREADY = 1'b0;
        check("ready_after_b", {AWREADY, WREADY, WEN, WRESPREADY}, 64'hC);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        do_txn(32'h10,  32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 3, 0);
        do_txn(32'h24,  32'h12345678, 4'h3, 2, 5, 1, 1'b1, 0, 0);
        do_txn(32'h400, 32'h11111111, 4'hF, 0, 0, 0, 1'b0, 1, 0);
        do_txn(32'h13,  32'h22222222, 4'hF, 1, 2, 0, 1'b0, 1, 0);
        do_txn(32'h20,  32'h33333333, 4'h0, 0, 0, 0, 1'b0, 2, 0);
        do_txn(32'h3FC, 32'h44444444, 4'h8, 1, 3, 2, 1'b0, 0, 0);
        do_txn(32'h30,  32'h55555555, 4'hF, 0, 0, 99, 1'b0, 4, 0);
        do_txn(32'h34,  32'h66666666, 4'hF, 0, 0, 14, 1'b0, 1, 0);
        do_txn(32'h40,  32'h77777777, 4'hF, 0, 0, 99, 1'b0, 1, 1);
        do_txn(32'h44,  32'h88888888, 4'hF, 0, 0, 0, 1'b0, 1, 0);
        do_txn(32'h48,  32'h99999999, 4'hF, 0, 0, 0, 1'b0, 1, 2);
        do_txn(32'h4C,  32'hAAAAAAAA, 4'hF, 2, 1, 0, 1'b0, 1, 0);
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] a;
            logic [3:0]  s;
            kind = $urandom % 8;
            if (kind == 0)      a = 32'd1024 + ($urandom % 4096) * 32'd4;
            else if (kind == 1) a = ($urandom % 256) * 32'd4 + 32'd1 + ($urandom % 3);
            else                a = ($urandom % 256) * 32'd4;
            s = ($urandom % 6 == 0) ? 4'd0 : 4'($urandom);
            do_txn(a, $urandom, s, $urandom % 3, $urandom % 6, $urandom % 20,
                   1'($urandom % 2), $urandom % 5, 0);
        end
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_write_ctrl.md
# axi_write_ctrl

AXI4-Lite slave write-execution stage: accepts the AW and W channel handshakes in either order, checks the address, performs one write on the memory interface, and hands a one-cycle response strobe (WRESPREADY/WRESP) to the downstream B-channel stage. It blocks new AW/W acceptance until that stage reports, via BRESPREADY, that the master has taken the response. This guarantees one outstanding write transaction at a time.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width (32 or 64)
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- MEM_BYTES, 1024, size of the decoded memory window in bytes; legal addresses are 0..MEM_BYTES-1
- TIMEOUT, 15, maximum WEN cycles without MACK before the write is abandoned (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- AWVALID  in  1  master write-address valid
- AWREADY  out  1  slave ready for write address
- AWADDR  in  ADDR_WIDTH  write address
- WVALID  in  1  master write-data valid
- WREADY  out  1  slave ready for write data
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  STRB_WIDTH  byte-lane strobes
- WEN  out  1  memory write enable
- MADDR  out  ADDR_WIDTH  memory address (captured AWADDR)
- MSTRB  out  STRB_WIDTH  memory byte enables (captured WSTRB)
- MDATA  out  DATA_WIDTH  memory write data (captured WDATA)
- MACK  in  1  memory write complete; sampled only while WEN=1
- MERR  in  1  memory error, qualified by MACK
- WRESPREADY  out  1  one-cycle strobe to B stage: response valid
- WRESP  out  2  response code; OKAY=2'b00, SLVERR=2'b10
- BRESPREADY  in  1  pulse from B stage: master accepted BRESP

## Operation
States:
- IDLE: collects AW and W.
- WRITE: memory access.
- RESP: issues the response strobe.
- WAIT_B: waits for the B stage to finish.

IDLE:
- AWREADY=1 until AW handshake (AWVALID&&AWREADY), then AWADDR latched and AWREADY=0 from the next cycle.
- WREADY/WDATA/WSTRB handled identically and independently.
- Both handshakes may occur in the same cycle or in any order, any distance apart.
- Once both are held, the next state is chosen as follows:
  - Address illegal (AWADDR ≥ MEM_BYTES, or low log2(STRB_WIDTH) bits nonzero): go to RESP with WRESP=SLVERR; no memory access.
  - Address legal and WSTRB==0: go to RESP with OKAY; no memory access.
  - Otherwise: go to WRITE.

WRITE:
- WEN=1; MADDR/MSTRB/MDATA stable for the whole state.
- Wait counter starts at 1 on entry and increments each cycle.
- MACK=1: WRESP = MERR ? SLVERR : OKAY; go to RESP.
- If MACK is still 0 in the cycle where the counter equals TIMEOUT: WRESP=SLVERR; go to RESP.

RESP:
- WRESPREADY=1 for exactly one cycle, then go to WAIT_B.

WAIT_B:
- Wait for BRESPREADY=1, then go to IDLE.
- AWREADY and WREADY are set to 1 on the IDLE entry cycle.

General rules:
- BRESPREADY outside WAIT_B is ignored.
- MACK outside WRITE is ignored.
- AWVALID/WVALID while the corresponding READY=0 are ignored; the master holds them per AXI.
- WRESP holds its value from RESP until the next RESP; it is defined only while WRESPREADY=1.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- During reset and on the first cycle after reset, all outputs are 0:
  - AWREADY, WREADY, WEN, WRESPREADY, WRESP, MADDR, MSTRB, MDATA.
  - State=IDLE; captured flags cleared.
- AWREADY=WREADY=1 from the second cycle after resetn rises.
- Let cycle T be the cycle in which the last of the AW/W handshakes completes:
  - WEN=1 in T+1.
  - If MACK=1 in T+1, WRESPREADY=1 in T+2.
  - Illegal address or WSTRB==0: WRESPREADY=1 in T+1 and WEN never asserts.
- BRESPREADY at cycle U: state=IDLE and AWREADY=WREADY=1 at U+1. The earliest next AW handshake is U+1.
- Timeout: WEN is high for exactly TIMEOUT cycles; WRESPREADY in the following cycle.
- Reset mid-operation (any state):
  - Next edge returns to IDLE, drops WEN/WRESPREADY, and discards captured AW/W and any pending response.

## Test plan
- Reset: hold resetn=0 for 3 cycles with AWVALID=WVALID=1 -> all outputs 0; no handshake; AWREADY=WREADY=1 two cycles after release.
- Simultaneous AW/W, AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=4'hF, MACK at first WEN cycle -> WEN one cycle with MADDR=0x10 and MDATA=0xDEADBEEF; WRESPREADY one cycle with WRESP=00; BRESPREADY 3 cycles later -> AWREADY back next cycle.
- W first, AW 5 cycles later; MACK with MERR=1 -> WREADY low after the W handshake, WRESP=10, a single WEN burst.
- AWADDR=0x400 (=MEM_BYTES), then AWADDR=0x13 (misaligned) -> no WEN; WRESPREADY at T+1 with WRESP=10 each time; WSTRB=0 at 0x20 -> no WEN, WRESP=00.
- MACK never asserted, TIMEOUT=15 -> WEN high exactly 15 cycles; WRESP=10; back-to-back second write is not accepted before BRESPREADY.
- resetn pulsed low during WRITE and during WAIT_B -> WEN/WRESPREADY drop; no response issued; next transaction completes normally with OKAY.
